// File: rtl/mips_cpu_divider_pipe.sv
// Multi-cycle restoring divider for MIPS32 DIV/DIVU: Quotient feeds LO, Remainder feeds HI.
// Optional build macro DIVIDER_FASTPATH_EN skips ITER for |Divisor|==1 or |Dividend|<|Divisor|.
//
// state | meaning
// IDLE  | waiting for start; results and dbz held
// PREP  | form operand magnitudes and result signs; catch divide-by-zero
// ITER  | restoring shift-subtract, STEP quotient bits per cycle
// FIX   | apply result signs and register Quotient/Remainder
// DONE  | raise done for one cycle, drop busy
module mips_cpu_divider_pipe #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             done,
   output logic             dbz,
   output logic             busy
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             sgn_reg;
   logic             q_neg;
   logic             r_neg;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [CW-1:0]    cnt;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // Magnitudes are unsigned WIDTH-bit values, so the most-negative operand maps cleanly.
   always_comb begin
      a_neg = sgn_reg & a_reg[WIDTH-1];
      b_neg = sgn_reg & b_reg[WIDTH-1];
      a_mag = a_neg ? (~a_reg + 1'b1) : a_reg;
      b_mag = b_neg ? (~b_reg + 1'b1) : b_reg;
   end

   // quo doubles as the dividend shift register; quotient bits enter at the bottom.
   always_comb begin
      rem_nxt = rem;
      quo_nxt = quo;
      for (int i = 0; i < STEP; i++) begin
         rem_nxt = {rem_nxt[WIDTH-1:0], quo_nxt[WIDTH-1]};
         quo_nxt = {quo_nxt[WIDTH-2:0], 1'b0};
         if (rem_nxt >= {1'b0, b_reg}) begin
            rem_nxt    = rem_nxt - {1'b0, b_reg};
            quo_nxt[0] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sgn_reg   <= 1'b0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         rem       <= '0;
         quo       <= '0;
         cnt       <= '0;
         Quotient  <= '0;
         Remainder <= '0;
         done      <= 1'b0;
         dbz       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg   <= Dividend;
                  b_reg   <= Divisor;
                  sgn_reg <= is_signed;
                  busy    <= 1'b1;
                  state   <= PREP;
               end
            end
            PREP: begin
               q_neg <= a_neg ^ b_neg;
               r_neg <= a_neg;
               if (b_reg == '0) begin
                  Quotient  <= '1;
                  Remainder <= a_reg;
                  dbz       <= 1'b1;
                  state     <= DONE;
               end else begin
                  b_reg <= b_mag;
`ifdef DIVIDER_FASTPATH_EN
                  if (b_mag == WIDTH'(1)) begin
                     quo   <= a_mag;
                     rem   <= '0;
                     state <= FIX;
                  end else if (a_mag < b_mag) begin
                     quo   <= '0;
                     rem   <= {1'b0, a_mag};
                     state <= FIX;
                  end else begin
                     quo   <= a_mag;
                     rem   <= '0;
                     cnt   <= CW'(N);
                     state <= ITER;
                  end
`else
                  quo   <= a_mag;
                  rem   <= '0;
                  cnt   <= CW'(N);
                  state <= ITER;
`endif
               end
            end
            ITER: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1))
                  state <= FIX;
            end
            FIX: begin
               Quotient  <= q_neg ? (~quo + 1'b1) : quo;
               Remainder <= r_neg ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
               dbz       <= 1'b0;
               state     <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_divider_pipe.sv
// Scoreboard bench for mips_cpu_divider_pipe: directed corner cases plus a random sweep
// checked against plain SystemVerilog / and % on sign- or zero-extended operands.
module tb_mips_cpu_divider_pipe;

   parameter int WIDTH = 32;
   parameter int STEP  = 1;
   localparam int N = WIDTH / STEP;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             dbz;
      int               lat;
      longint           t0;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             is_signed = 1'b0;
   logic [WIDTH-1:0] Dividend = '0;
   logic [WIDTH-1:0] Divisor = '0;
   logic [WIDTH-1:0] Quotient;
   logic [WIDTH-1:0] Remainder;
   logic             done;
   logic             dbz;
   logic             busy;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   exp_t   sbq[$];
   exp_t   last_e;

   mips_cpu_divider_pipe #(.WIDTH(WIDTH), .STEP(STEP)) dut (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .Dividend(Dividend), .Divisor(Divisor),
      .Quotient(Quotient), .Remainder(Remainder),
      .done(done), .dbz(dbz), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic longint sx(input logic [WIDTH-1:0] v, input logic sg);
      longint x;
      x = longint'(v);
      if (sg && v[WIDTH-1]) x = x - (longint'(1) << WIDTH);
      return x;
   endfunction

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sg);
      exp_t   e;
      longint va, vb, q, r, ma, mb;
      va = sx(a, sg);
      vb = sx(b, sg);
      e.t0 = 0;
      if (vb == 0) begin
         e.q   = '1;
         e.r   = a;
         e.dbz = 1'b1;
         e.lat = 2;
      end else begin
         q = va / vb;
         r = va % vb;
         e.q   = q[WIDTH-1:0];
         e.r   = r[WIDTH-1:0];
         e.dbz = 1'b0;
         ma = (va < 0) ? -va : va;
         mb = (vb < 0) ? -vb : vb;
`ifdef DIVIDER_FASTPATH_EN
         e.lat = (mb == 1 || ma < mb) ? 3 : N + 3;
`else
         e.lat = N + 3;
`endif
      end
      return e;
   endfunction

   // Drive a request; caller must be between a falling and the next rising edge.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sg);
      exp_t e;
      e = model(a, b, sg);
      Dividend  = a;
      Divisor   = b;
      is_signed = sg;
      start     = 1'b1;
      @(posedge clk);
      #1;
      e.t0 = cyc;
      sbq.push_back(e);
      last_e = e;
      start     = 1'b0;
      Dividend  = WIDTH'($urandom);
      Divisor   = WIDTH'($urandom);
      is_signed = 1'($urandom);
      chk("busy_after_start", 64'(busy), 64'(1));
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      while (sbq.size() > 0 && n < lim) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("done_timeout", 64'(sbq.size()), 64'(0));
      sbq.delete();
   endtask

   task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sg);
      issue(a, b, sg);
      wait_idle(N + 20);
   endtask

   task automatic check_hold();
      repeat (3) @(negedge clk);
      chk("hold_quotient", 64'(Quotient), 64'(last_e.q));
      chk("hold_remainder", 64'(Remainder), 64'(last_e.r));
      chk("hold_dbz", 64'(dbz), 64'(last_e.dbz));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            if (sbq.size() == 0) begin
               chk("spurious_done", 64'(1), 64'(0));
            end else begin
               e = sbq.pop_front();
               chk("quotient", 64'(Quotient), 64'(e.q));
               chk("remainder", 64'(Remainder), 64'(e.r));
               chk("dbz", 64'(dbz), 64'(e.dbz));
               chk("latency", 64'(cyc - e.t0), 64'(e.lat));
               chk("busy_at_done", 64'(busy), 64'(0));
            end
         end
      end
   end

   initial begin : stimulus
      logic [WIDTH-1:0] mn;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      mn = '0;
      mn[WIDTH-1] = 1'b1;

      #1;
      chk("reset_quotient", 64'(Quotient), 64'(0));
      chk("reset_remainder", 64'(Remainder), 64'(0));
      chk("reset_flags", 64'({done, dbz, busy}), 64'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      run(WIDTH'(100), WIDTH'(7), 1'b0);
      check_hold();
      @(negedge clk);
      run(WIDTH'(-7), WIDTH'(2), 1'b1);
      run(WIDTH'(7), WIDTH'(-2), 1'b1);
      run(mn, '1, 1'b1);
      run(mn, '1, 1'b0);
      run(WIDTH'(1234), '0, 1'b0);
      check_hold();
      @(negedge clk);
      run(WIDTH'(9), WIDTH'(3), 1'b1);

      // Asynchronous reset in the middle of ITER.
      issue(WIDTH'(100), WIDTH'(3), 1'b0);
      repeat (11) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("midop_reset_quotient", 64'(Quotient), 64'(0));
      chk("midop_reset_remainder", 64'(Remainder), 64'(0));
      chk("midop_reset_flags", 64'({done, dbz, busy}), 64'(0));
      sbq.delete();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run(WIDTH'(50), WIDTH'(5), 1'b0);

      // A start pulse while busy must be ignored.
      issue(WIDTH'(100), WIDTH'(7), 1'b0);
      repeat (3) @(negedge clk);
      Dividend = WIDTH'(9);
      Divisor  = WIDTH'(9);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_idle(N + 20);
      check_hold();
      @(negedge clk);

      // Random sweep, issued back-to-back as soon as each result is checked.
      for (int i = 0; i < 800; i++) begin
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = '1;
            2:       b = WIDTH'(1);
            3:       b = WIDTH'($urandom_range(1, 15));
            default: b = WIDTH'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0:       a = mn;
            1:       a = WIDTH'($urandom_range(0, 20));
            default: a = WIDTH'($urandom);
         endcase
         run(a, b, 1'($urandom));
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
